// File: rtl/stream_pkg.sv
// Shared definitions for SEND/ACK/COUNT/DATA token-stream blocks.
package stream_pkg;

    // Token count field carried beside every stream port.
    localparam int                        TOKEN_COUNT_W   = 16;
    localparam logic [TOKEN_COUNT_W-1:0]  TOKEN_COUNT_ONE = 16'h0001;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_fifo_core.sv
// DEPTH-entry FIFO: storage, wrapping pointers, occupancy and full/empty flags.
module stream_fifo_core
    import stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = lvl_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LVL_W-1:0]  level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic              do_push,  do_pop;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i  & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
        else if (do_pop && !do_push) level_d = level_q - LVL_W'(1);
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; entries are only read once level marks them valid.
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/stream_decim_fifo.sv
// Keeps 1 of every DECIM incoming tokens and buffers the kept ones in a FIFO.
module stream_decim_fifo
    import stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int DECIM  = 1,
    parameter int LVL_W  = lvl_width(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     In1_SEND,
    input  logic [DATA_W-1:0]        In1_DATA,
    input  logic [TOKEN_COUNT_W-1:0] In1_COUNT,
    output logic                     In1_ACK,
    input  logic                     Out1_RDY,
    input  logic                     Out1_ACK,
    output logic                     Out1_SEND,
    output logic [DATA_W-1:0]        Out1_DATA,
    output logic [TOKEN_COUNT_W-1:0] Out1_COUNT,
    output logic [LVL_W-1:0]         level
);

    // Parameter legality checked at elaboration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_decim_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (DECIM < 1) begin : g_bad_decim
        $error("stream_decim_fifo: DECIM must be at least 1");
    end

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PH_W-1:0] phase_q, phase_d;
    logic            keep;
    logic            full;
    logic            empty;
    logic            push;

    // Interface-compatibility inputs with no function here.
    logic unused_inputs;
    assign unused_inputs = ^{In1_COUNT, Out1_ACK};

    assign keep       = (phase_q == '0);
    // Dropped tokens are always taken; a kept token waits while full, even if a pop is under way.
    assign In1_ACK    = In1_SEND & ~rst_i & (~keep | ~full);
    assign push       = In1_ACK & keep;
    assign Out1_SEND  = Out1_RDY & ~empty & ~rst_i;
    assign Out1_COUNT = TOKEN_COUNT_ONE;

    // Decimation phase advances on every accepted token, wrapping at DECIM-1.
    always_comb begin
        phase_d = phase_q;
        if (In1_ACK) phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
    end

    // Phase register; reset makes the next token a kept one.
    always_ff @(posedge clk_i) begin
        if (rst_i) phase_q <= '0;
        else       phase_q <= phase_d;
    end

    stream_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .wr_data_i (In1_DATA),
        .pop_i     (Out1_SEND),
        .rd_data_o (Out1_DATA),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level)
    );

endmodule
